// File: rtl/rr_grant_sched.sv
// Round-robin grant scheduler for one shared multi-cycle resource.
// Holds a registered one-hot grant until done_i or a hold timeout, then rotates priority.
module rr_grant_sched #(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 16,
  parameter int IW       = $clog2(NREQ)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NREQ-1:0] req_i,
  input  logic            done_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   gnt_idx_o,
  output logic            busy_o,
  output logic            timeout_o,
  output logic            onehot_err_o
);

  localparam int CW = $clog2(MAX_HOLD) + 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_d;
  logic [IW-1:0]   idx_d;
  logic            busy_d, timeout_d;
  logic [IW-1:0]   cand, sel_idx;
  logic            sel_found;
  logic            onehot_bad;
  int              ones;

  // Search order ptr, ptr+1, ..., NREQ-1, 0, ..., ptr-1 with an explicit wrap,
  // so non-power-of-two NREQ never indexes past the last requester.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (int'(ptr_q) + i >= NREQ) cand = IW'(int'(ptr_q) + i - NREQ);
      else                         cand = IW'(int'(ptr_q) + i);
      if (!sel_found && req_i[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // req_i is a level sampled only in IDLE; done_i is a one-cycle completion
  // pulse honoured only in BUSY. Neither side has back-pressure.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_o;
    idx_d     = gnt_idx_o;
    busy_d    = busy_o;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        gnt_d  = '0;
        idx_d  = '0;
        busy_d = 1'b0;
        if (sel_found) begin
          gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;
          idx_d   = sel_idx;
          busy_d  = 1'b1;
          ptr_d   = (sel_idx == IW'(NREQ - 1)) ? '0 : sel_idx + 1'b1;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (done_i || cnt_q == CW'(MAX_HOLD - 1)) begin
          gnt_d     = '0;
          idx_d     = '0;
          busy_d    = 1'b0;
          timeout_d = !done_i;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ones = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_o[i]) ones = ones + 1;
    end
    onehot_bad = busy_o ? (ones != 1) : (gnt_o != '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      gnt_o        <= '0;
      gnt_idx_o    <= '0;
      busy_o       <= 1'b0;
      timeout_o    <= 1'b0;
      onehot_err_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      gnt_o        <= gnt_d;
      gnt_idx_o    <= idx_d;
      busy_o       <= busy_d;
      timeout_o    <= timeout_d;
      onehot_err_o <= onehot_err_o | onehot_bad;
    end
  end

endmodule

// File: tb/tb_rr_grant_sched.sv
// Bench for rr_grant_sched: directed checks on a 4x16 instance, random traffic on a 3x2 instance,
// both compared every cycle against a grant-ownership model.
module tb_rr_grant_sched;

  logic       clk = 1'b0;
  logic       rst4, done4, rst3, done3;
  logic [3:0] req4, gnt4;
  logic [1:0] idx4, idx3;
  logic       busy4, tmo4, err4;
  logic [2:0] req3, gnt3;
  logic       busy3, tmo3, err3;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  rr_grant_sched #(.NREQ(4), .MAX_HOLD(16)) u_dut4 (
    .clk_i(clk), .rst_i(rst4), .req_i(req4), .done_i(done4),
    .gnt_o(gnt4), .gnt_idx_o(idx4), .busy_o(busy4), .timeout_o(tmo4), .onehot_err_o(err4));

  rr_grant_sched #(.NREQ(3), .MAX_HOLD(2)) u_dut3 (
    .clk_i(clk), .rst_i(rst3), .req_i(req3), .done_i(done3),
    .gnt_o(gnt3), .gnt_idx_o(idx3), .busy_o(busy3), .timeout_o(tmo3), .onehot_err_o(err3));

  // Model: who owns the resource, for how many cycles so far, and who is next in line.
  typedef struct {
    int busy;
    int owner;
    int ptr;
    int held;
    int tmo;
  } mdl_t;

  mdl_t m4 = '{0, 0, 0, 0, 0};
  mdl_t m3 = '{0, 0, 0, 0, 0};

  function automatic mdl_t step(mdl_t m, int n, int mh, logic [7:0] req, logic done, logic rst);
    mdl_t r = m;
    r.tmo = 0;
    if (rst) begin
      r.busy = 0; r.owner = 0; r.ptr = 0; r.held = 0;
    end else if (m.busy == 0) begin
      for (int o = 0; o < n; o++) begin
        int k;
        k = (m.ptr + o) % n;
        if (r.busy == 0 && req[k]) begin
          r.busy = 1; r.owner = k; r.ptr = (k + 1) % n; r.held = 1;
        end
      end
    end else if (done) begin
      r.busy = 0;
    end else if (m.held >= mh) begin
      r.busy = 0; r.tmo = 1;
    end else begin
      r.held = m.held + 1;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    m4 = step(m4, 4, 16, {4'b0, req4}, done4, rst4);
    m3 = step(m3, 3, 2, {5'b0, req3}, done3, rst3);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("gnt4",  32'(gnt4),  m4.busy != 0 ? 32'(1) << m4.owner : 32'(0));
      check("idx4",  32'(idx4),  m4.busy != 0 ? 32'(m4.owner) : 32'(0));
      check("busy4", 32'(busy4), 32'(m4.busy));
      check("tmo4",  32'(tmo4),  32'(m4.tmo));
      check("err4",  32'(err4),  32'(0));
      check("gnt3",  32'(gnt3),  m3.busy != 0 ? 32'(1) << m3.owner : 32'(0));
      check("idx3",  32'(idx3),  m3.busy != 0 ? 32'(m3.owner) : 32'(0));
      check("busy3", 32'(busy3), 32'(m3.busy));
      check("tmo3",  32'(tmo3),  32'(m3.tmo));
      check("err3",  32'(err3),  32'(0));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic release4();
    done4 = 1'b1;
    tick();
    done4 = 1'b0;
  endtask

  task automatic directed4();
    logic [3:0] seq [4];
    int n_busy;
    seq[0] = 4'b0010; seq[1] = 4'b0100; seq[2] = 4'b1000; seq[3] = 4'b0001;
    rst4 = 1'b0;
    tick();
    check("first_gnt", 32'(gnt4), 32'h1);
    for (int i = 0; i < 4; i++) begin
      release4();
      check("bubble", 32'(busy4), 32'h0);
      tick();
      check("rotate", 32'(gnt4), 32'(seq[i]));
    end
    // Grant to 1 sets ptr=2; then 0011 must wrap to requester 0.
    req4 = 4'b0010; release4(); tick();
    check("gnt_r1", 32'(gnt4), 32'h2);
    req4 = 4'b0011; release4(); tick();
    check("wrap_r0", 32'(gnt4), 32'h1);
    req4 = 4'b0010; release4(); tick();
    check("gnt_r1_idx", 32'(idx4), 32'h1);
    // Grant to 3 with no done: exactly 16 busy cycles then a timeout pulse.
    req4 = 4'b1000; release4(); tick();
    check("gnt_r3", 32'(gnt4), 32'h8);
    req4 = 4'b0000;
    n_busy = 0;
    for (int i = 0; i < 40 && busy4; i++) begin
      n_busy++;
      tick();
    end
    check("hold_len", 32'(n_busy), 32'd16);
    check("tmo_pulse", 32'(tmo4), 32'h1);
    check("tmo_gnt", 32'(gnt4), 32'h0);
    req4 = 4'b1111;
    tick();
    check("ptr_after_tmo", 32'(gnt4), 32'h1);
    check("tmo_clear", 32'(tmo4), 32'h0);
    // done_i on the last allowed cycle: release without timeout.
    req4 = 4'b0000;
    for (int i = 0; i < 15; i++) tick();
    done4 = 1'b1;
    tick();
    done4 = 1'b0;
    check("done_wins_busy", 32'(busy4), 32'h0);
    check("done_wins_tmo", 32'(tmo4), 32'h0);
    // Requester drops its request while granted.
    req4 = 4'b0100;
    tick();
    check("gnt_r2", 32'(gnt4), 32'h4);
    req4 = 4'b0000;
    for (int i = 0; i < 5; i++) tick();
    check("hold_after_drop", 32'(gnt4), 32'h4);
    release4();
    check("drop_release", 32'(gnt4), 32'h0);
    release4();
    check("idle_done_gnt", 32'(gnt4), 32'h0);
    check("idle_done_tmo", 32'(tmo4), 32'h0);
    req4 = 4'b1111;
    tick();
    check("ptr_kept", 32'(gnt4), 32'h8);
    // Reset mid-BUSY.
    rst4 = 1'b1;
    tick();
    check("rst_gnt", 32'(gnt4), 32'h0);
    check("rst_busy", 32'(busy4), 32'h0);
    check("rst_tmo", 32'(tmo4), 32'h0);
    rst4 = 1'b0;
    tick();
    check("rst_ptr0", 32'(gnt4), 32'h1);
    release4();
    req4 = 4'b0000;
    tick();
  endtask

  task automatic random3();
    int waited;
    rst3 = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      req3  = 3'($urandom_range(0, 7));
      done3 = ($urandom_range(0, 3) == 0);
      tick();
      if (c == 5000) begin
        req3 = 3'b111; done3 = 1'b0;
        waited = 0;
        while (!busy3 && waited < 20) begin
          tick();
          waited++;
        end
        check("rand_busy_seen", 32'(busy3), 32'h1);
        rst3 = 1'b1;
        tick();
        check("rand_rst_gnt", 32'(gnt3), 32'h0);
        check("rand_rst_busy", 32'(busy3), 32'h0);
        check("rand_rst_tmo", 32'(tmo3), 32'h0);
        rst3 = 1'b0;
      end
    end
    done3 = 1'b0;
    req3  = 3'b000;
  endtask

  initial begin
    rst4 = 1'b1; rst3 = 1'b1;
    req4 = 4'b1111; done4 = 1'b0;
    req3 = 3'b000;  done3 = 1'b0;
    tick();
    tick();
    chk_en = 1'b1;
    check("rst_state_gnt", 32'(gnt4), 32'h0);
    check("rst_state_idx", 32'(idx4), 32'h0);
    check("rst_state_err", 32'(err4), 32'h0);
    fork
      directed4();
      random3();
    join
    tick();
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
